// File: rtl/muldiv_unit.sv
// muldiv_unit: RV M-extension multiply / iterative restoring divide.
// Ports: clk, reset (sync, active-low), flush, in_valid/in_ready,
//   op, rs1, rs2, rd -> out_valid/out_ready, result, out_rd, busy.
// Optional: `define MULDIV_WORD_OPS_EN enables ops 8-12 (XLEN 64).
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [RD_W-1:0] rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] out_rd,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] X_MIN =
    {1'b1, {(XLEN-1){1'b0}}};

`ifdef MULDIV_WORD_OPS_EN
  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] v
  );
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(
    input logic [31:0] v
  );
    logic [XLEN-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction
`endif

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   dvd;
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_q;
  logic [RD_W-1:0]   rd_q;
  logic              rem_q;
  logic              neg_q;
  logic              neg_r;
`ifdef MULDIV_WORD_OPS_EN
  logic              word_q;
`endif

  logic              acc;
  logic              word;
  logic              is_mul;
  logic              is_div;
  logic              d_sgn;
  logic              d_rem;
  logic              m_sa;
  logic              m_sb;
  logic              neg_a;
  logic              neg_b;
  logic              dz;
  logic              ovf;
  logic              fast;
  logic [2*XLEN-1:0] pa;
  logic [2*XLEN-1:0] pb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   da;
  logic [XLEN-1:0]   db;
  logic [XLEN-1:0]   ma;
  logic [XLEN-1:0]   mb;
  logic [XLEN-1:0]   x_min;
  logic [XLEN-1:0]   rem_z;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   q_raw;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   fix_res;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = res_q;
  assign out_rd    = rd_q;

  assign acc = reset && in_valid && !flush &&
               (state == S_IDLE);

  always_comb begin
    word = 1'b0;
`ifdef MULDIV_WORD_OPS_EN
    word = (XLEN == 64) &&
           (op >= OP_MULW) && (op <= OP_REMUW);
`endif
    is_mul = (op <= OP_MULHU) ||
             (word && op == OP_MULW);
    is_div = ((op >= OP_DIV) && (op <= OP_REMU)) ||
             (word && op != OP_MULW);
    d_sgn  = (op == OP_DIV) || (op == OP_REM) ||
             (op == OP_DIVW) || (op == OP_REMW);
    d_rem  = (op == OP_REM) || (op == OP_REMU) ||
             (op == OP_REMW) || (op == OP_REMUW);
  end

  // Extending both operands to 2*XLEN makes one
  // truncated product correct for every sign mix.
  always_comb begin
    m_sa = (op == OP_MULH) || (op == OP_MULHSU);
    m_sb = (op == OP_MULH);
    pa   = {{XLEN{m_sa & rs1[XLEN-1]}}, rs1};
    pb   = {{XLEN{m_sb & rs2[XLEN-1]}}, rs2};
    prod = pa * pb;
    mul_res = prod[2*XLEN-1:XLEN];
    unique case (1'b1)
      (op == OP_MUL): mul_res = prod[XLEN-1:0];
`ifdef MULDIV_WORD_OPS_EN
      (word && op == OP_MULW):
        mul_res = sext32(prod[31:0]);
`endif
      default: ;
    endcase
  end

  // Word ops divide the extended 32-bit values,
  // so the full-width special-case tests still apply.
  always_comb begin
    da    = rs1;
    db    = rs2;
    x_min = X_MIN;
    rem_z = rs1;
`ifdef MULDIV_WORD_OPS_EN
    if (word) begin
      da    = d_sgn ? sext32(rs1[31:0])
                    : zext32(rs1[31:0]);
      db    = d_sgn ? sext32(rs2[31:0])
                    : zext32(rs2[31:0]);
      x_min = sext32(32'h8000_0000);
      rem_z = sext32(rs1[31:0]);
    end
`endif
    dz    = (db == '0);
    ovf   = d_sgn && (da == x_min) && (db == '1);
    neg_a = d_sgn && da[XLEN-1];
    neg_b = d_sgn && db[XLEN-1];
    ma    = neg_a ? -da : da;
    mb    = neg_b ? -db : db;
    fast  = !is_div || dz || ovf;
    fast_res = '0;
    unique case (1'b1)
      is_mul:          fast_res = mul_res;
      (is_div && dz):  fast_res = d_rem ? rem_z : '1;
      (is_div && ovf): fast_res = d_rem ? '0 : da;
      default: ;
    endcase
  end

  always_comb begin
    rem_sh = {rem, dvd[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    q_raw  = dvd;
`ifdef MULDIV_WORD_OPS_EN
    if (word_q) q_raw = zext32(dvd[31:0]);
`endif
    q_fix   = neg_q ? -q_raw : q_raw;
    r_fix   = neg_r ? -rem : rem;
    fix_res = rem_q ? r_fix : q_fix;
`ifdef MULDIV_WORD_OPS_EN
    if (word_q) fix_res = sext32(fix_res[31:0]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      res_q <= '0;
      rd_q  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (acc) begin
            rd_q <= rd;
            if (fast) begin
              res_q <= fast_res;
              state <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          res_q <= fix_res;
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Quotient bits shift into dvd as the dividend
  // bits shift out of its top.
  always_ff @(posedge clk) begin
    if (acc) begin
      dvd   <= ma;
      dvs   <= mb;
      rem   <= '0;
      cnt   <= CW'(XLEN-1);
      rem_q <= d_rem;
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
`ifdef MULDIV_WORD_OPS_EN
      word_q <= word;
      if (word) begin
        dvd <= ma << (XLEN-32);
        cnt <= CW'(31);
      end
`endif
    end else if (state == S_DIV) begin
      dvd <= {dvd[XLEN-2:0], !diff[XLEN]};
      rem <= diff[XLEN] ? rem_sh[XLEN-1:0]
                        : diff[XLEN-1:0];
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN 64).
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_muldiv_unit;

  localparam int XLEN = 64;
  localparam int RD_W = 5;

`ifdef MULDIV_WORD_OPS_EN
  localparam logic [63:0] DIVW_EXP  = 64'hFFFF_FFFF_8000_0000;
  localparam int          DIVW_LAT  = 34;
  localparam logic [63:0] MULW_EXP  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] REMW_EXP  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          REMW_LAT  = 34;
  localparam logic [63:0] REMUW_EXP = 64'd5;
`else
  localparam logic [63:0] DIVW_EXP  = 64'd0;
  localparam int          DIVW_LAT  = 1;
  localparam logic [63:0] MULW_EXP  = 64'd0;
  localparam logic [63:0] REMW_EXP  = 64'd0;
  localparam int          REMW_LAT  = 1;
  localparam logic [63:0] REMUW_EXP = 64'd0;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [RD_W-1:0] rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] out_rd;
  logic            busy;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   checked = 1'b0;

  muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_rd    (out_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!out_valid) begin
      checked = 1'b0;
    end else if (!checked) begin
      checked = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_result"}, result, e.res);
        chk({e.tag, "_rd"}, 64'(out_rd), 64'(e.rd));
        chk({e.tag, "_latency"}, 64'(cyc - e.c0),
            64'(e.lat));
      end
    end
  end

  task automatic issue(input string       tag,
                       input logic [3:0]  o,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [4:0]  r,
                       input logic [63:0] e,
                       input int          lat,
                       input bit          push);
    int   n;
    exp_t x;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({tag, "_wait_in_ready"}, 64'(in_ready), 64'd1);
      return;
    end
    op       = o;
    rs1      = a;
    rs2      = b;
    rd       = r;
    in_valid = 1'b1;
    if (push) begin
      x.tag = tag;
      x.res = e;
      x.rd  = r;
      x.lat = lat;
      x.c0  = cyc;
      sb.push_back(x);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((!in_ready || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    rs1       = '0;
    rs2       = '0;
    rd        = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    issue("mul", 4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
          5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1'b1);
    issue("mulhu", 4'd3, ONES, ONES,
          5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1'b1);
    issue("mulhsu", 4'd2, ONES, 64'd2,
          5'd3, ONES, 1, 1'b1);
    issue("mulh_pos", 4'd1, 64'h4000_0000_0000_0000,
          64'd4, 5'd4, 64'd1, 1, 1'b1);
    issue("mulh_neg", 4'd1, ONES, ONES,
          5'd5, 64'd0, 1, 1'b1);
    issue("div", 4'd4, M7, 64'd2,
          5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1);
    issue("rem", 4'd6, M7, 64'd2,
          5'd7, ONES, 66, 1'b1);
    issue("div_negb", 4'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
          5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1);
    issue("rem_negb", 4'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
          5'd9, 64'd1, 66, 1'b1);
    issue("divu_z", 4'd5, 64'd7, 64'd0,
          5'd10, ONES, 1, 1'b1);
    issue("rem_z", 4'd6, 64'd5, 64'd0,
          5'd11, 64'd5, 1, 1'b1);
    issue("div_ovf", 4'd4, MINV, ONES,
          5'd12, MINV, 1, 1'b1);
    issue("rem_ovf", 4'd6, MINV, ONES,
          5'd13, 64'd0, 1, 1'b1);
    issue("divu_big", 4'd5, ONES, 64'd3,
          5'd14, 64'h5555_5555_5555_5555, 66, 1'b1);
    issue("remu", 4'd7, 64'd100, 64'd7,
          5'd15, 64'd2, 66, 1'b1);
    issue("divw", 4'd9, 64'h0000_0000_8000_0000, 64'd1,
          5'd16, DIVW_EXP, DIVW_LAT, 1'b1);
    issue("mulw", 4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2,
          5'd18, MULW_EXP, 1, 1'b1);
    issue("remw", 4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2,
          5'd19, REMW_EXP, REMW_LAT, 1'b1);
    issue("remuw_z", 4'd12, 64'hFFFF_FFFF_0000_0005,
          64'h0000_0001_0000_0000,
          5'd20, REMUW_EXP, 1, 1'b1);
    issue("undef", 4'd13, 64'd5, 64'd7,
          5'd21, 64'd0, 1, 1'b1);
    drain();

    op       = 4'd0;
    rs1      = 64'd3;
    rs2      = 64'd3;
    rd       = 5'd22;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_accept_busy", 64'(busy), 64'd0);
    chk("flush_accept_valid", 64'(out_valid), 64'd0);

    issue("div_flush", 4'd4, M7, 64'd2,
          5'd23, 64'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (80) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    drain();
    out_ready = 1'b0;
    issue("mul_hold", 4'd0, 64'd6, 64'd7,
          5'd9, 64'd42, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_result", result, 64'd42);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);

    issue("div_rst", 4'd5, 64'd100, 64'd7,
          5'd17, 64'd0, 0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_out_rd", 64'(out_rd), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    issue("mul_after_rst", 4'd0, 64'd5, ONES,
          5'd2, 64'hFFFF_FFFF_FFFF_FFFB, 1, 1'b1);
    drain();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
